// File: rtl/sap_pkg.sv
// Shared opcodes, FSM states, ALU selects and instruction-field helpers for the SAP core.
package sap_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_LDA = 4'h1;
  localparam opcode_t OP_ADD = 4'h2;
  localparam opcode_t OP_SUB = 4'h3;
  localparam opcode_t OP_STA = 4'h4;
  localparam opcode_t OP_LDI = 4'h5;
  localparam opcode_t OP_JMP = 4'h6;
  localparam opcode_t OP_JC  = 4'h7;
  localparam opcode_t OP_JZ  = 4'h8;
  localparam opcode_t OP_INC = 4'h9;
  localparam opcode_t OP_DEC = 4'hA;
  localparam opcode_t OP_OUT = 4'hE;
  localparam opcode_t OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_EXEC0,
    S_EXEC1,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_INC,
    ALU_DEC
  } alu_op_t;

  // Helpers take the IR zero-extended to a fixed width so any DATA_W fits.
  localparam int unsigned IR_MAX_W = 64;

  function automatic opcode_t ir_opcode(input logic [IR_MAX_W-1:0] ir, input int unsigned dw);
    return opcode_t'(ir >> (dw - 4));
  endfunction

  function automatic logic [IR_MAX_W-1:0] ir_low(input logic [IR_MAX_W-1:0] ir, input int unsigned w);
    return ir & ((IR_MAX_W'(1) << w) - IR_MAX_W'(1));
  endfunction

  function automatic logic uses_mem(input opcode_t op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational accumulator ALU: add/sub against a memory word, increment/decrement.
// Carry means carry-out for ADD/INC and "no borrow" for SUB/DEC.
module sap_alu
  import sap_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_res,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum   = '0;
    o_carry = 1'b0;
    case (i_op)
      ALU_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        o_carry = w_sum[DATA_W];
      end
      ALU_SUB: begin
        w_sum   = {1'b0, i_a} - {1'b0, i_b};
        o_carry = (i_a >= i_b);
      end
      ALU_INC: begin
        w_sum   = {1'b0, i_a} + (DATA_W+1)'(1);
        o_carry = w_sum[DATA_W];
      end
      ALU_DEC: begin
        w_sum   = {1'b0, i_a} - (DATA_W+1)'(1);
        o_carry = |i_a;
      end
      default: begin
        w_sum   = '0;
        o_carry = 1'b0;
      end
    endcase
  end

  assign o_res  = w_sum[DATA_W-1:0];
  assign o_zero = (o_res == '0);

endmodule

// File: rtl/sap_cpu.sv
// SAP accumulator CPU: 3-cycle instructions, 4 for memory operands (LDA/ADD/SUB/STA).
// Program port and start are only honoured while idle or halted.
module sap_cpu
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              busy,
  output logic              carry,
  output logic              zero
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_mar, w_mar_nxt;
  logic [DATA_W-1:0] r_ir, w_ir_nxt;
  logic [DATA_W-1:0] r_a, w_a_nxt;
  logic [DATA_W-1:0] r_out, w_out_nxt;
  logic              r_out_vld, w_out_vld_nxt;
  logic              r_carry, w_carry_nxt;
  logic              r_zero, w_zero_nxt;
  logic              w_sta_we;
  logic [DATA_W-1:0] r_mem [DEPTH];

  opcode_t           w_opc;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_operand;
  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c, w_alu_z;
  alu_op_t           w_alu_op;
  logic              w_ctrl_ok;

  assign w_opc     = ir_opcode(IR_MAX_W'(r_ir), DATA_W);
  assign w_addr    = ADDR_W'(ir_low(IR_MAX_W'(r_ir), ADDR_W));
  assign w_operand = DATA_W'(ir_low(IR_MAX_W'(r_ir), DATA_W - 4));
  assign w_mem_rd  = r_mem[r_mar];
  assign w_ctrl_ok = (r_state == S_IDLE) || (r_state == S_HALT);

  always_comb begin
    case (w_opc)
      OP_SUB:  w_alu_op = ALU_SUB;
      OP_INC:  w_alu_op = ALU_INC;
      OP_DEC:  w_alu_op = ALU_DEC;
      default: w_alu_op = ALU_ADD;
    endcase
  end

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .i_a    (r_a),
    .i_b    (w_mem_rd),
    .i_op   (w_alu_op),
    .o_res  (w_alu_res),
    .o_carry(w_alu_c),
    .o_zero (w_alu_z)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_mar_nxt     = r_mar;
    w_ir_nxt      = r_ir;
    w_a_nxt       = r_a;
    w_out_nxt     = r_out;
    w_out_vld_nxt = 1'b0;
    w_carry_nxt   = r_carry;
    w_zero_nxt    = r_zero;
    w_sta_we      = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_pc_nxt    = '0;
          w_mar_nxt   = '0;
          w_ir_nxt    = '0;
          w_a_nxt     = '0;
          w_carry_nxt = 1'b0;
          w_zero_nxt  = 1'b0;
          w_state_nxt = S_FETCH0;
        end
      end
      S_FETCH0: begin
        w_mar_nxt   = r_pc;
        w_state_nxt = S_FETCH1;
      end
      S_FETCH1: begin
        w_ir_nxt    = w_mem_rd;
        w_pc_nxt    = r_pc + ADDR_W'(1);
        w_state_nxt = S_EXEC0;
      end
      S_EXEC0: begin
        if (uses_mem(w_opc)) begin
          w_mar_nxt   = w_addr;
          w_state_nxt = S_EXEC1;
        end else begin
          w_state_nxt = S_FETCH0;
          case (w_opc)
            OP_LDI: w_a_nxt = w_operand;
            OP_JMP: w_pc_nxt = w_addr;
            OP_JC:  if (r_carry) w_pc_nxt = w_addr;
            OP_JZ:  if (r_zero) w_pc_nxt = w_addr;
            OP_INC, OP_DEC: begin
              w_a_nxt     = w_alu_res;
              w_carry_nxt = w_alu_c;
              w_zero_nxt  = w_alu_z;
            end
            OP_OUT: begin
              w_out_nxt     = r_a;
              w_out_vld_nxt = 1'b1;
            end
            OP_HLT: w_state_nxt = S_HALT;
            default: ;
          endcase
        end
      end
      S_EXEC1: begin
        w_state_nxt = S_FETCH0;
        case (w_opc)
          OP_LDA: w_a_nxt = w_mem_rd;
          OP_ADD, OP_SUB: begin
            w_a_nxt     = w_alu_res;
            w_carry_nxt = w_alu_c;
            w_zero_nxt  = w_alu_z;
          end
          OP_STA: w_sta_we = 1'b1;
          default: ;
        endcase
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_mar     <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_mar     <= w_mar_nxt;
      r_ir      <= w_ir_nxt;
      r_a       <= w_a_nxt;
      r_out     <= w_out_nxt;
      r_out_vld <= w_out_vld_nxt;
      r_carry   <= w_carry_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  // Memory has no reset; rst only suppresses a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_ctrl_ok && prog_we) r_mem[prog_addr] <= prog_data;
      else if (w_sta_we)        r_mem[r_mar]     <= r_a;
    end
  end

  assign out_data  = r_out;
  assign out_valid = r_out_vld;
  assign halted    = (r_state == S_HALT);
  assign busy      = !w_ctrl_ok;
  assign carry     = r_carry;
  assign zero      = r_zero;

endmodule

// File: tb/tb_sap_cpu.sv
// Bench for sap_cpu: directed programs plus random programs against an instruction-level model.
module tb_sap_cpu;

  localparam int MAXC = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s8, we8, vld8, h8, b8, c8, z8;
  logic [3:0] pa8;
  logic [7:0] pd8, out8;
  logic s12, we12, vld12, h12, b12, c12, z12;
  logic [7:0] pa12;
  logic [11:0] pd12, out12;

  sap_cpu #(.DATA_W(8), .ADDR_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .prog_we(we8), .prog_addr(pa8), .prog_data(pd8),
    .out_data(out8), .out_valid(vld8), .halted(h8), .busy(b8), .carry(c8), .zero(z8)
  );

  sap_cpu #(.DATA_W(12), .ADDR_W(8)) u_dut12 (
    .clk(clk), .rst(rst), .start(s12), .prog_we(we12), .prog_addr(pa12), .prog_data(pd12),
    .out_data(out12), .out_valid(vld12), .halted(h12), .busy(b12), .carry(c12), .zero(z12)
  );

  int n_pass = 0;
  int n_total = 0;

  int m_mem [16];
  int m_out;
  bit m_halted;
  int exp_busy [MAXC];
  int exp_halt [MAXC];
  int exp_vld  [MAXC];
  int exp_out  [MAXC];
  int exp_c    [MAXC];
  int exp_z    [MAXC];

  int first_vld, first_halt;
  logic [7:0] outs [$];
  logic vc [$];
  logic vz [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  // Executes whole instructions; every effect becomes visible at the first
  // cycle of the following instruction.
  function automatic void model_run(input int ncyc);
    int a, c, z, pc, pend, t, ins, op, ad, len;
    bit done;
    a = 0; c = 0; z = 0; pc = 0; pend = 0; t = 0; done = 0;
    m_halted = 0;
    while (t < ncyc && !done) begin
      ins = m_mem[pc];
      op  = ins >> 4;
      ad  = ins & 15;
      pc  = (pc + 1) % 16;
      len = (op >= 1 && op <= 4) ? 4 : 3;
      for (int e = t; e < t + len && e < ncyc; e++) begin
        exp_busy[e] = 1; exp_halt[e] = 0; exp_vld[e] = (e == t) ? pend : 0;
        exp_out[e] = m_out; exp_c[e] = c; exp_z[e] = z;
      end
      pend = 0;
      case (op)
        1:  a = m_mem[ad];
        2:  begin a = a + m_mem[ad]; c = (a > 255) ? 1 : 0; a = a & 255; z = (a == 0) ? 1 : 0; end
        3:  begin c = (a >= m_mem[ad]) ? 1 : 0; a = (a - m_mem[ad]) & 255; z = (a == 0) ? 1 : 0; end
        4:  m_mem[ad] = a;
        5:  a = ad;
        6:  pc = ad;
        7:  if (c != 0) pc = ad;
        8:  if (z != 0) pc = ad;
        9:  begin a = (a + 1) & 255; c = (a == 0) ? 1 : 0; z = c; end
        10: begin c = (a != 0) ? 1 : 0; a = (a - 1) & 255; z = (a == 0) ? 1 : 0; end
        14: begin m_out = a; pend = 1; end
        15: begin
          done = 1;
          m_halted = (t + 3 < ncyc);
          for (int e = t + 3; e < ncyc; e++) begin
            exp_busy[e] = 0; exp_halt[e] = 1; exp_vld[e] = 0;
            exp_out[e] = m_out; exp_c[e] = c; exp_z[e] = z;
          end
        end
        default: ;
      endcase
      t = t + len;
    end
  endfunction

  task automatic load8(input int a, input int d);
    @(negedge clk);
    we8 = 1'b1; pa8 = 4'(a); pd8 = 8'(d);
    m_mem[a] = d;
    @(negedge clk);
    we8 = 1'b0;
  endtask

  task automatic load12(input int a, input int d);
    @(negedge clk);
    we12 = 1'b1; pa12 = 8'(a); pd12 = 12'(d);
    @(negedge clk);
    we12 = 1'b0;
  endtask

  // Word 0 is corrupted first and rewritten in the start cycle itself.
  task automatic run8(input int ncyc, input string tag);
    int w0;
    w0 = m_mem[0];
    model_run(ncyc);
    first_vld = -1; first_halt = -1;
    outs.delete(); vc.delete(); vz.delete();
    @(negedge clk);
    we8 = 1'b1; pa8 = 4'd0; pd8 = 8'(~w0);
    @(negedge clk);
    s8 = 1'b1; pd8 = 8'(w0);
    @(negedge clk);
    s8 = 1'b0; we8 = 1'b0;
    for (int e = 0; e < ncyc; e++) begin
      chk({tag, "_busy"},   32'(b8),   exp_busy[e]);
      chk({tag, "_halted"}, 32'(h8),   exp_halt[e]);
      chk({tag, "_vld"},    32'(vld8), exp_vld[e]);
      chk({tag, "_out"},    32'(out8), exp_out[e]);
      chk({tag, "_carry"},  32'(c8),   exp_c[e]);
      chk({tag, "_zero"},   32'(z8),   exp_z[e]);
      if (vld8 === 1'b1) begin
        if (first_vld < 0) first_vld = e;
        outs.push_back(out8); vc.push_back(c8); vz.push_back(z8);
      end
      if (h8 === 1'b1 && first_halt < 0) first_halt = e;
      if (exp_busy[e] != 0 && $urandom_range(0, 2) == 0) begin
        we8 = 1'b1; pa8 = 4'(e); pd8 = 8'($urandom);
      end else begin
        we8 = 1'b0;
      end
      @(negedge clk);
    end
    we8 = 1'b0;
    if (!m_halted) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_out = 0;
    end
  endtask

  initial begin
    int p1 [16];
    int p2 [16];
    int p3 [16];
    int v12_cyc [$];
    logic [11:0] v12_val [$];
    p1 = '{8'h19, 8'h2A, 8'hE0, 8'hF0, 0, 0, 0, 0, 0, 8'h1C, 8'h0E, 0, 0, 0, 0, 0};
    p2 = '{8'h53, 8'h3E, 8'h7F, 8'hE0, 8'h55, 8'h3E, 8'h8C, 8'hF0,
           8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'hF0, 8'h05, 8'hF0};
    p3 = '{8'h1E, 8'h90, 8'hE0, 8'hA0, 8'h4D, 8'h50, 8'h1D, 8'hE0,
           8'h6F, 0, 0, 0, 0, 0, 8'hFF, 8'h00};

    rst = 1'b1; s8 = 0; we8 = 0; pa8 = 0; pd8 = 0; s12 = 0; we12 = 0; pa12 = 0; pd12 = 0;
    m_out = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out8", 32'(out8), 0);  chk("rst_vld8", 32'(vld8), 0);
    chk("rst_h8", 32'(h8), 0);      chk("rst_b8", 32'(b8), 0);
    chk("rst_c8", 32'(c8), 0);      chk("rst_z8", 32'(z8), 0);
    chk("rst_out12", 32'(out12), 0); chk("rst_b12", 32'(b12), 0);
    chk("rst_h12", 32'(h12), 0);     chk("rst_c12", 32'(c12), 0);

    // Basic LDA/ADD/OUT/HLT program.
    for (int i = 0; i < 16; i++) load8(i, p1[i]);
    run8(20, "tp1");
    chk("tp1_vld_cycle", 32'(first_vld), 11);
    chk("tp1_halt_cycle", 32'(first_halt), 14);
    chk("tp1_out_count", 32'(outs.size()), 1);
    chk("tp1_out", 32'(out8), 32'h2A);
    chk("tp1_carry", 32'(c8), 0);
    chk("tp1_zero", 32'(z8), 0);

    // Reset during EXEC1 of STA 9 must drop the write.
    load8(0, 8'h57); load8(1, 8'h49); load8(2, 8'hF0);
    @(negedge clk); s8 = 1'b1;
    @(negedge clk); s8 = 1'b0;
    repeat (6) @(negedge clk);
    chk("sta_busy_pre_rst", 32'(b8), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("sta_rst_out", 32'(out8), 0); chk("sta_rst_vld", 32'(vld8), 0);
    chk("sta_rst_busy", 32'(b8), 0);  chk("sta_rst_halt", 32'(h8), 0);
    chk("sta_rst_c", 32'(c8), 0);     chk("sta_rst_z", 32'(z8), 0);
    rst = 1'b0;
    m_out = 0;
    for (int i = 0; i < 4; i++) load8(i, p1[i]);
    run8(20, "rerun");
    chk("rerun_out", 32'(out8), 32'h2A);
    chk("rerun_vld_cycle", 32'(first_vld), 11);

    // SUB flags, JC not taken, JZ taken.
    for (int i = 0; i < 16; i++) load8(i, p2[i]);
    run8(60, "subj");
    chk("subj_out_count", 32'(outs.size()), 2);
    if (outs.size() == 2) begin
      chk("subj_out0", 32'(outs[0]), 32'hFE);
      chk("subj_c0", 32'(vc[0]), 0); chk("subj_z0", 32'(vz[0]), 0);
      chk("subj_out1", 32'(outs[1]), 0);
      chk("subj_c1", 32'(vc[1]), 1); chk("subj_z1", 32'(vz[1]), 1);
    end
    chk("subj_halted", 32'(h8), 1);

    // INC/DEC wrap, STA/LDA round trip, PC wrap from 15 to 0.
    for (int i = 0; i < 16; i++) load8(i, p3[i]);
    run8(80, "incdec");
    chk("incdec_out_count_ge3", 32'(outs.size() >= 3), 1);
    if (outs.size() >= 3) begin
      chk("inc_out", 32'(outs[0]), 0);
      chk("inc_c", 32'(vc[0]), 1); chk("inc_z", 32'(vz[0]), 1);
      chk("dec_sta_lda_out", 32'(outs[1]), 32'hFF);
      chk("dec_c", 32'(vc[1]), 0); chk("dec_z", 32'(vz[1]), 0);
      chk("wrap_out", 32'(outs[2]), 0);
    end

    // Random programs.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) load8(i, $urandom_range(0, 255));
      run8(80, "rand");
    end

    // Wide configuration: long jump and full-width carry.
    load12(0, 12'h6C8);   load12(1, 12'hF00);   load12(8, 12'hF00);
    load12(8'hC8, 12'h1D0); load12(8'hC9, 12'hE00); load12(8'hCA, 12'h2D1);
    load12(8'hCB, 12'hE00); load12(8'hCC, 12'hF00);
    load12(8'hD0, 12'hFFF); load12(8'hD1, 12'h001);
    @(negedge clk); s12 = 1'b1;
    @(negedge clk); s12 = 1'b0;
    for (int e = 0; e < 40; e++) begin
      if (vld12 === 1'b1) begin v12_cyc.push_back(e); v12_val.push_back(out12); end
      @(negedge clk);
    end
    chk("w12_out_count", 32'(v12_cyc.size()), 2);
    if (v12_cyc.size() == 2) begin
      chk("w12_jmp_cycle", 32'(v12_cyc[0]), 10);
      chk("w12_lda_out", 32'(v12_val[0]), 32'hFFF);
      chk("w12_add_cycle", 32'(v12_cyc[1]), 17);
      chk("w12_add_out", 32'(v12_val[1]), 0);
    end
    chk("w12_carry", 32'(c12), 1);
    chk("w12_zero", 32'(z12), 1);
    chk("w12_halted", 32'(h12), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
